// File: rtl/devtbl_seq.sv
// devtbl_seq: device table slave on the wishbone-pipelined bus.
// Exposes the SoC info block and the per-device (id, mapsz, useirq) list.
// A sequential scanner walks the device slots one per cycle to work out
// this block's own map size, so that the first RAM device lands at RAMBASE.
// Build option: define DEVTBL_WDOG_EN to add the watchdog (command 7, INFO[7]).
module devtbl_seq #(
  parameter int ARCHBITSZ   = 32,
  parameter int RAMCACHESZ  = 2,
  parameter int PRELDRADDR  = 0,
  parameter int DEVMAPCNT   = 3,
  parameter int SOCID       = 0,
  parameter int BLKDEVMAPSZ = 1024,
  parameter int RAMBASE     = 4096,
  parameter int RSTHOLD     = 4,
  parameter int WDOGCYCLES  = 1000000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  output logic                           rst0_o,
  output logic                           rst1_o,
  output logic                           rst2_o,
  input  logic                           wb_cyc_i,
  input  logic                           wb_stb_i,
  input  logic                           wb_we_i,
  input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0] wb_addr_i,
  input  logic [ARCHBITSZ/8-1:0]         wb_sel_i,
  input  logic [ARCHBITSZ-1:0]           wb_dat_i,
  output logic                           wb_bsy_o,
  output logic                           wb_ack_o,
  output logic [ARCHBITSZ-1:0]           wb_dat_o,
  output logic [ARCHBITSZ-1:0]           wb_mapsz_o,
  output logic                           mapvld_o,
  input  logic [ARCHBITSZ*DEVMAPCNT-1:0] dev_id_i,
  input  logic [ARCHBITSZ*DEVMAPCNT-1:0] dev_mapsz_i,
  input  logic [DEVMAPCNT-1:0]           dev_useirq_i
);

  localparam int W    = ARCHBITSZ;
  localparam int AW   = ARCHBITSZ - $clog2(ARCHBITSZ/8);
  localparam int SW   = $clog2(DEVMAPCNT + 1);
  localparam int TBLN = 1 << SW;
  localparam int HW   = $clog2(RSTHOLD + 1);

  localparam int SOCVERSION = 1;

  // Starting accumulator: space left between the block device and RAM.
  localparam logic [W-1:0] ACC_INIT =
    (RAMBASE > BLKDEVMAPSZ) ? W'(RAMBASE - BLKDEVMAPSZ) : '0;

  localparam logic [W-1:0] CMD_PWROFF    = W'(0);
  localparam logic [W-1:0] CMD_WRESET    = W'(1);
  localparam logic [W-1:0] CMD_CRESET    = W'(2);
  localparam logic [W-1:0] CMD_RRESET    = W'(3);
  localparam logic [W-1:0] CMD_RDSELINFO = W'(4);
  localparam logic [W-1:0] CMD_RDSELDEVS = W'(5);
  localparam logic [W-1:0] CMD_RESCAN    = W'(6);
`ifdef DEVTBL_WDOG_EN
  localparam logic [W-1:0] CMD_WDOGKICK  = W'(7);
`endif

  typedef enum logic {
    SCAN,
    DONE
  } scan_state_t;

  // Per-slot views of the packed inputs, padded to a power of two so the
  // scanner index can address them without range issues.
  logic [W-1:0] id_arr     [TBLN];
  logic [W-1:0] dmap_arr   [TBLN];
  logic         useirq_arr [TBLN];

  for (genvar g = 0; g < TBLN; g++) begin : g_tbl
    if (g < DEVMAPCNT) begin : g_used
      assign id_arr[g]     = dev_id_i[g*W +: W];
      assign dmap_arr[g]   = dev_mapsz_i[g*W +: W];
      assign useirq_arr[g] = dev_useirq_i[g];
    end else begin : g_pad
      assign id_arr[g]     = '0;
      assign dmap_arr[g]   = '0;
      assign useirq_arr[g] = 1'b0;
    end
  end

  logic sel_unused;
  assign sel_unused = ^wb_sel_i;

  // Bus request register and decoded commands.
  logic          accept;
  logic          s1_vld_q;
  logic          s1_we_q;
  logic [AW-1:0] s1_addr_q;
  logic [W-1:0]  s1_dat_q;
  logic          cmd_wr;
  logic          rescan;
  logic          rrst_cmd;

  // Scanner state.
  scan_state_t   state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [SW-1:0] idx_q, idx_d;
  logic          scanerr_q, scanerr_d;
  logic          mapvld_d;
  logic [W-1:0]  mapsz_d;
  logic [W-1:0]  scan_id;
  logic [W-1:0]  scan_sz;
  logic [W-1:0]  sub_acc;

  // Control registers.
  logic          rdsel_q;
  logic          rrst_pend_q;
  logic [HW-1:0] rst2_cnt_q;
  logic          rst2_sticky = 1'b0;
`ifdef DEVTBL_WDOG_EN
  logic          wdog_arm_q;
  logic [W-1:0]  wdog_cnt_q;
`endif

  // Read path.
  logic [AW-1:0] dev_n;
  logic [SW-1:0] dev_idx;
  logic [W-1:0]  dev_sz;
  logic [W-1:0]  rdata;

  assign wb_bsy_o = (state_q == SCAN);
  assign accept   = wb_cyc_i & wb_stb_i & ~wb_bsy_o;
  assign cmd_wr   = s1_vld_q & s1_we_q;
  assign rescan   = cmd_wr && (s1_dat_q == CMD_RESCAN);
  assign rrst_cmd = cmd_wr && (s1_dat_q == CMD_RRESET);

  // Capture an accepted request; it is executed one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_we_q   <= 1'b0;
      s1_addr_q <= '0;
      s1_dat_q  <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_we_q   <= wb_we_i;
        s1_addr_q <= wb_addr_i;
        s1_dat_q  <= wb_dat_i;
      end
    end
  end

  // Scanner state register; reset starts a fresh scan from slot 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SCAN;
      acc_q      <= ACC_INIT;
      idx_q      <= SW'(2);
      scanerr_q  <= 1'b0;
      mapvld_o   <= 1'b0;
      wb_mapsz_o <= ACC_INIT;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      scanerr_q  <= scanerr_d;
      mapvld_o   <= mapvld_d;
      wb_mapsz_o <= mapsz_d;
    end
  end

  // Scanner next state: subtract one slot per cycle, stop at the first
  // RAM device (id 1) or at the end of the table, clamping at zero.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    scanerr_d = scanerr_q;
    mapvld_d  = mapvld_o;
    mapsz_d   = wb_mapsz_o;
    scan_id   = id_arr[idx_q];
    scan_sz   = dmap_arr[idx_q];
    sub_acc   = (scan_sz > acc_q) ? '0 : (acc_q - scan_sz);
    unique case (state_q)
      SCAN: begin
        if (scan_id == W'(1)) begin
          state_d  = DONE;
          mapvld_d = 1'b1;
          mapsz_d  = acc_q;
        end else begin
          acc_d = sub_acc;
          if (scan_sz > acc_q) scanerr_d = 1'b1;
          idx_d = idx_q + SW'(1);
          if (idx_q == SW'(DEVMAPCNT - 1)) begin
            state_d  = DONE;
            mapvld_d = 1'b1;
            mapsz_d  = sub_acc;
          end
        end
      end
      DONE: begin
      end
    endcase
    if (rescan) begin
      state_d   = SCAN;
      acc_d     = ACC_INIT;
      idx_d     = SW'(2);
      scanerr_d = 1'b0;
      mapvld_d  = 1'b0;
    end
  end

  // Execute write commands (and the watchdog expiry when built in).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst0_o      <= 1'b0;
      rst1_o      <= 1'b0;
      rdsel_q     <= 1'b0;
      rrst_pend_q <= 1'b0;
`ifdef DEVTBL_WDOG_EN
      wdog_arm_q  <= 1'b0;
      wdog_cnt_q  <= '0;
`endif
    end else begin
      rrst_pend_q <= 1'b0;
`ifdef DEVTBL_WDOG_EN
      if (wdog_arm_q) begin
        if (wdog_cnt_q == '0) begin
          rst1_o     <= 1'b1;
          rst0_o     <= 1'b0;
          wdog_arm_q <= 1'b0;
        end else begin
          wdog_cnt_q <= wdog_cnt_q - W'(1);
        end
      end
`endif
      if (cmd_wr) begin
        case (s1_dat_q)
          CMD_PWROFF: begin
            rst0_o <= 1'b1;
            rst1_o <= 1'b0;
          end
          CMD_WRESET: begin
            rst0_o <= 1'b0;
            rst1_o <= 1'b1;
          end
          CMD_CRESET: begin
            rst0_o <= 1'b1;
            rst1_o <= 1'b1;
          end
          CMD_RRESET:    rrst_pend_q <= 1'b1;
          CMD_RDSELINFO: rdsel_q <= 1'b1;
          CMD_RDSELDEVS: rdsel_q <= 1'b0;
`ifdef DEVTBL_WDOG_EN
          CMD_WDOGKICK: begin
            wdog_arm_q <= 1'b1;
            wdog_cnt_q <= W'(WDOGCYCLES);
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  // Pre-loader reset pulse: starts the cycle after the ack, lasts RSTHOLD.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst2_o     <= 1'b0;
      rst2_cnt_q <= '0;
    end else if (rrst_pend_q) begin
      rst2_o     <= 1'b1;
      rst2_cnt_q <= HW'(RSTHOLD);
    end else if (rst2_cnt_q > HW'(1)) begin
      rst2_cnt_q <= rst2_cnt_q - HW'(1);
    end else begin
      rst2_o     <= 1'b0;
      rst2_cnt_q <= '0;
    end
  end

  // Remember that the pre-loader was rerun; survives the bus reset.
  always_ff @(posedge clk_i) begin
    if (rrst_cmd) rst2_sticky <= 1'b1;
  end

  // Read data for the registered request, from the INFO or DEVS view.
  always_comb begin
    rdata   = '0;
    dev_n   = s1_addr_q >> 1;
    dev_idx = dev_n[SW-1:0];
    if (dev_idx == SW'(0))      dev_sz = W'(BLKDEVMAPSZ);
    else if (dev_idx == SW'(1)) dev_sz = wb_mapsz_o;
    else                        dev_sz = dmap_arr[dev_idx];
    if (rdsel_q) begin
      case (s1_addr_q)
        AW'(0): rdata = W'(SOCVERSION);
        AW'(1): rdata = W'(RAMCACHESZ);
        AW'(2): rdata = {{(W-2){1'b0}}, rst1_o, rst0_o};
        AW'(3): rdata = rst2_sticky ? '0 : W'(PRELDRADDR);
        AW'(4): rdata = W'(SOCID);
        AW'(5): rdata = W'(DEVMAPCNT);
        AW'(6): rdata = {{(W-2){1'b0}}, scanerr_q, mapvld_o};
`ifdef DEVTBL_WDOG_EN
        AW'(7): rdata = wdog_cnt_q;
`endif
        default: rdata = '0;
      endcase
    end else if (dev_n < AW'(DEVMAPCNT)) begin
      if (s1_addr_q[0]) rdata = {dev_sz[W-1:1], useirq_arr[dev_idx]};
      else              rdata = id_arr[dev_idx];
    end
  end

  // Response stage: ack two cycles after acceptance, data alongside.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= s1_vld_q;
      if (s1_vld_q && !s1_we_q) wb_dat_o <= rdata;
    end
  end

endmodule
